sha256_msg_padder: RTL and testbench

Front-end stage of the SHA-256 accelerator.
- Reads the message bytes from message memory and applies SHA-256 padding: 0x80 marker, zero fill, then the 64-bit big-endian bit length.
- Emits the resulting single 512-bit block as sixteen 32-bit big-endian words W0..W15 over a valid/ready stream.
- The stream feeds the message-schedule/compression core.
- Messages are at most 55 bytes, so exactly one block is produced per go.

---
 rtl/sha256_pkg.sv | 34 +++
 rtl/sha256_msg_padder.sv | 143 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 accelerator front end: block geometry,
// padding constants, padder state encoding and the per-byte pipeline slot.
package sha256_pkg;

  localparam int MAX_MESSAGE_LENGTH = 55;
  localparam int SYMBOL_WIDTH       = 8;
  localparam int WORDS_PER_BLOCK    = 16;

  // Length port carries 0..MAX (and beyond, saturated); the address covers 0..MAX-1.
  localparam int LEN_W  = $clog2(MAX_MESSAGE_LENGTH) + 1;
  localparam int ADDR_W = $clog2(MAX_MESSAGE_LENGTH);

  localparam logic [7:0] PAD_MARKER = 8'h80;

  // Byte positions of the two non-zero bytes of the 64-bit length field.
  localparam logic [5:0] LEN_HI_POS = 6'd62;
  localparam logic [5:0] LEN_LO_POS = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EMIT,
    ST_DONE
  } padder_state_t;

  // One byte in flight: either a memory byte (value arrives from memory)
  // or a pad/length byte whose value is already known.
  typedef struct packed {
    logic       valid;
    logic       is_mem;
    logic [7:0] value;
  } byte_slot_t;

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: fetches up to 55 message bytes, appends the 0x80
// marker, zero fill and the big-endian bit length, and streams the single
// 512-bit block as sixteen big-endian 32-bit words.
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    xxx__dut__go,
  input  logic [LEN_W-1:0]        xxx__dut__msg_length,
  output logic [ADDR_W-1:0]       dut__msg__address,
  output logic                    dut__msg__enable,
  output logic                    dut__msg__write,
  input  logic [SYMBOL_WIDTH-1:0] msg__dut__data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [31:0]             w_data,
  output logic [3:0]              w_index,
  output logic                    busy,
  output logic                    done
);

  padder_state_t state, state_next;

  logic [LEN_W-1:0] msg_len;   // saturated length L
  logic [2:0]       rd_cnt;    // byte requests issued for the current word (0..4)
  logic [1:0]       cap_cnt;   // bytes already shifted into w_data
  byte_slot_t       slot_req;  // request issued, memory is sampling this cycle
  byte_slot_t       slot_cap;  // byte whose memory data is on the bus this cycle
  byte_slot_t       req;
  logic [5:0]       cur_byte;

  // Classifies byte b of the padded block for a message of len bytes.
  function automatic byte_slot_t select_byte(input logic [5:0] b, input logic [LEN_W-1:0] len);
    logic [15:0] bit_len;
    byte_slot_t  slot;
    bit_len     = {6'd0, len, 3'd0};
    slot.valid  = 1'b1;
    slot.is_mem = 1'b0;
    slot.value  = 8'h00;
    if ({1'b0, b} < len) begin
      slot.is_mem = 1'b1;
    end else if ({1'b0, b} == len) begin
      slot.value = PAD_MARKER;
    end else if (b == LEN_HI_POS) begin
      slot.value = bit_len[15:8];
    end else if (b == LEN_LO_POS) begin
      slot.value = bit_len[7:0];
    end
    return slot;
  endfunction

  assign cur_byte = {w_index, rd_cnt[1:0]};
  assign req      = select_byte(cur_byte, msg_len);

  // Status outputs are straight decodes of the state register.
  assign w_valid         = (state == ST_EMIT);
  assign busy            = (state == ST_READ) || (state == ST_EMIT);
  assign done            = (state == ST_DONE);
  assign dut__msg__write = 1'b0;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path assigned, so no latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (xxx__dut__go) state_next = ST_READ;
      ST_READ: if (slot_cap.valid && cap_cnt == 2'd3) state_next = ST_EMIT;
      ST_EMIT: if (w_ready) begin
        state_next = (w_index == 4'(WORDS_PER_BLOCK - 1)) ? ST_DONE : ST_READ;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: byte requests, two-stage tracking matching the memory latency,
  // byte capture into w_data, and word sequencing.
  // NOTE: every datapath register is reset so an abort leaves no stale word
  // or pending read behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_len           <= '0;
      rd_cnt            <= '0;
      cap_cnt           <= '0;
      slot_req          <= '0;
      slot_cap          <= '0;
      w_data            <= '0;
      w_index           <= '0;
      dut__msg__address <= '0;
      dut__msg__enable  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          dut__msg__enable <= 1'b0;
          if (xxx__dut__go) begin
            msg_len  <= (xxx__dut__msg_length > LEN_W'(MAX_MESSAGE_LENGTH))
                        ? LEN_W'(MAX_MESSAGE_LENGTH) : xxx__dut__msg_length;
            rd_cnt   <= '0;
            cap_cnt  <= '0;
            w_index  <= '0;
            slot_req <= '0;
            slot_cap <= '0;
          end
        end
        ST_READ: begin
          if (rd_cnt < 3'd4) begin
            dut__msg__enable <= req.is_mem;
            if (req.is_mem) dut__msg__address <= ADDR_W'(cur_byte);
            slot_req <= req;
            rd_cnt   <= rd_cnt + 3'd1;
          end else begin
            dut__msg__enable <= 1'b0;
            slot_req         <= '0;
          end
          slot_cap <= slot_req;
          if (slot_cap.valid) begin
            w_data  <= {w_data[23:0], slot_cap.is_mem ? msg__dut__data : slot_cap.value};
            cap_cnt <= cap_cnt + 2'd1;
          end
        end
        ST_EMIT: begin
          dut__msg__enable <= 1'b0;
          if (w_ready) begin
            rd_cnt  <= '0;
            cap_cnt <= '0;
            if (w_index != 4'(WORDS_PER_BLOCK - 1)) w_index <= w_index + 4'd1;
          end
        end
        default: dut__msg__enable <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: synchronous message memory,
// byte-array padding reference model, directed and randomized blocks.
module tb_sha256_msg_padder;

  logic        clk;
  logic        reset;
  logic        go;
  logic [6:0]  msg_length;
  logic [5:0]  msg_address;
  logic        msg_enable;
  logic        msg_write;
  logic [7:0]  msg_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_index;
  logic        busy;
  logic        done;

  sha256_msg_padder dut (
    .clk                  (clk),
    .reset                (reset),
    .xxx__dut__go         (go),
    .xxx__dut__msg_length (msg_length),
    .dut__msg__address    (msg_address),
    .dut__msg__enable     (msg_enable),
    .dut__msg__write      (msg_write),
    .msg__dut__data       (msg_data),
    .w_valid              (w_valid),
    .w_ready              (w_ready),
    .w_data               (w_data),
    .w_index              (w_index),
    .busy                 (busy),
    .done                 (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [64];
  logic [31:0] exp_w [16];
  int          cur_len;
  int          reads;
  int          bad_reads;
  int          n_cmp;
  int          n_mis;

  initial begin
    reads     = 0;
    bad_reads = 0;
  end

  // Message memory: data valid the cycle after enable; logs every read.
  always @(posedge clk) begin
    if (msg_enable) begin
      msg_data  <= mem[msg_address];
      reads     <= reads + 1;
      if (int'(msg_address) >= cur_len) bad_reads <= bad_reads + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: lay out the 64-byte padded block, then pack big-endian words.
  task automatic build_expected(input int len);
    logic [7:0] blk [64];
    longint     bits;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < len; i++) blk[i] = mem[i];
    blk[len] = 8'h80;
    bits = longint'(len) * 8;
    for (int k = 0; k < 8; k++) blk[63 - k] = 8'(bits >> (8 * k));
    for (int w = 0; w < 16; w++)
      exp_w[w] = {blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]};
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {msg_address, msg_enable, msg_write, w_valid, w_data, w_index, busy, done}, 64'd0);
  endtask

  // Runs one block; optional stall, go abuse, and mid-block abort.
  task automatic run_block(input int len_req, input int stall_word, input int stall_cycles,
                           input bit abuse, input int abort_word);
    int len_eff;
    int reads0;
    int bad0;
    int reads_s;
    int k;
    logic [31:0] held_data;
    len_eff = (len_req > 55) ? 55 : len_req;
    cur_len = len_eff;
    build_expected(len_eff);
    reads0 = reads;
    bad0   = bad_reads;
    @(negedge clk);
    go = 1'b1;
    msg_length = 7'(len_req);
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    msg_length = 7'($urandom_range(0, 127));
    check($sformatf("busy_after_go_L%0d", len_req), busy, 1);
    for (int w = 0; w < 16; w++) begin
      k = 0;
      while (!w_valid && k < 40) begin
        if (abuse && w == 2 && k == 2) begin
          go = 1'b1;
          msg_length = 7'd9;
        end else begin
          go = 1'b0;
        end
        if (w == abort_word && k == 3) begin
          #2 reset = 1'b0;
          #1 check_all_zero("async_abort_outputs");
          return;
        end
        @(posedge clk);
        k++;
        @(negedge clk);
      end
      go = 1'b0;
      check($sformatf("latency_w%0d_L%0d", w, len_req), k, 6);
      check($sformatf("index_w%0d", w), w_index, w);
      check($sformatf("data_w%0d_L%0d", w, len_req), w_data, exp_w[w]);
      check("write_low", msg_write, 0);
      if (abuse && w == 3) begin
        go = 1'b1;
        msg_length = 7'd1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        check("go_in_emit_data", w_data, exp_w[w]);
        check("go_in_emit_valid", w_valid, 1);
      end
      if (w == stall_word) begin
        reads_s   = reads;
        held_data = w_data;
        repeat (stall_cycles) begin
          @(posedge clk);
          @(negedge clk);
        end
        check("stall_data_held", w_data, held_data);
        check("stall_index_held", w_index, w);
        check("stall_valid_held", w_valid, 1);
        check("stall_no_reads", reads, reads_s);
      end
      w_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w_ready = 1'b0;
    end
    check($sformatf("done_pulse_L%0d", len_req), {busy, done}, 2'b01);
    @(negedge clk);
    check("done_one_cycle", {busy, done}, 2'b00);
    check($sformatf("read_count_L%0d", len_req), reads - reads0, len_eff);
    check("no_reads_beyond_L", bad_reads - bad0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_mis      = 0;
    cur_len    = 0;
    reset      = 1'b0;
    go         = 1'b0;
    msg_length = '0;
    w_ready    = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_release");

    // "abc"
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    run_block(3, -1, 0, 1'b0, -1);
    check("abc_w0", exp_w[0], 32'h61626380);

    // Empty message
    run_block(0, -1, 0, 1'b0, -1);

    // Full-length message and saturated over-length request
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    run_block(55, -1, 0, 1'b0, -1);
    run_block(60, -1, 0, 1'b0, -1);

    // Backpressure at W5
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    run_block(int'($urandom_range(10, 40)), 5, 10, 1'b0, -1);

    // go abuse in READ and EMIT
    run_block(int'($urandom_range(1, 55)), -1, 0, 1'b1, -1);

    // Reset mid-W7, then a clean block
    run_block(20, -1, 0, 1'b0, 7);
    repeat (2) @(negedge clk);
    check_all_zero("held_in_reset");
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check_all_zero("no_partial_after_release");
    run_block(20, -1, 0, 1'b0, -1);

    // Randomized lengths, contents and stalls
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_block(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                int'($urandom_range(1, 6)), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
